pwr_seq_ctrl: RTL and testbench

//  Rail power-sequencing controller for the baseboard CPLD, downstream of the 1s enable/disable delay timer.

---
 rtl/pwr_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_pwr_seq_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
// Rail power-sequencing controller: ordered bring-up gated on power-good, reverse-order shutdown, latched fault.
// Optional PG-low glitch filter in ON is enabled by defining PWR_SEQ_PG_FILTER_EN.
module pwr_seq_ctrl #(
    parameter int                NUM_RAILS  = 4,
    parameter int                IDX_W      = 2,
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  STEP_DLY   = 16'd2500,
    parameter logic [CNT_W-1:0]  PG_TIMEOUT = 16'd25000,
    parameter int                PG_FILT    = 8
) (
    input  logic                 SYSCLK,
    input  logic                 RESET,
    input  logic                 PWR_REQ,
    input  logic [NUM_RAILS-1:0] PG_IN,
    input  logic                 CLR_FAULT,
    output logic [NUM_RAILS-1:0] RAIL_EN,
    output logic                 PWR_OK,
    output logic                 FAULT,
    output logic [IDX_W-1:0]     FAULT_IDX
);

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_WAIT,
        S_UP_DLY,
        S_ON,
        S_DOWN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] STEP_LAST = STEP_DLY - CNT_ONE;
    localparam logic [CNT_W-1:0] PG_LAST   = PG_TIMEOUT - CNT_ONE;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RAILS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_RAILS-1:0]   railEn_q, railEn_d;
    logic                   pwrOk_q, pwrOk_d;
    logic                   fault_q, fault_d;
    logic [IDX_W-1:0]       faultIdx_q, faultIdx_d;
    logic [NUM_RAILS-1:0]   pgMeta_q, pgS_q;
    logic [NUM_RAILS-1:0]   onLost;
    logic [NUM_RAILS-1:0]   belowIdx, atOrBelowIdx;

    function automatic logic [IDX_W-1:0] lowestSet(input logic [NUM_RAILS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // PG inputs come straight from the regulators, so they are double-flopped before use.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            pgMeta_q <= '0;
            pgS_q    <= '0;
        end else begin
            pgMeta_q <= PG_IN;
            pgS_q    <= pgMeta_q;
        end
    end

`ifdef PWR_SEQ_PG_FILTER_EN
    localparam int               FILT_W    = $clog2(PG_FILT + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(PG_FILT - 1);

    logic [FILT_W-1:0] filt_q [NUM_RAILS];

    // Counters only run in ON; any good sample restarts the low-run count for that rail.
    always_ff @(posedge SYSCLK) begin
        for (int i = 0; i < NUM_RAILS; i++) begin
            if (RESET || state_q != S_ON || pgS_q[i]) begin
                filt_q[i] <= '0;
            end else if (filt_q[i] != FILT_LAST) begin
                filt_q[i] <= filt_q[i] + FILT_W'(1);
            end
        end
    end

    always_comb begin
        onLost = '0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            onLost[i] = !pgS_q[i] && (filt_q[i] == FILT_LAST);
        end
    end
`else
    assign onLost = ~pgS_q;
`endif

    always_comb begin
        belowIdx     = '0;
        atOrBelowIdx = '0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            belowIdx[j]     = IDX_W'(j) <  idx_q;
            atOrBelowIdx[j] = IDX_W'(j) <= idx_q;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q    <= S_OFF;
            idx_q      <= '0;
            cnt_q      <= '0;
            railEn_q   <= '0;
            pwrOk_q    <= 1'b0;
            fault_q    <= 1'b0;
            faultIdx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            railEn_q   <= railEn_d;
            pwrOk_q    <= pwrOk_d;
            fault_q    <= fault_d;
            faultIdx_q <= faultIdx_d;
        end
    end

    // Fault checks take priority over a request drop, which takes priority over normal stepping.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        railEn_d   = railEn_q;
        pwrOk_d    = pwrOk_q;
        fault_d    = fault_q;
        faultIdx_d = faultIdx_q;

        case (state_q)
            S_OFF: begin
                railEn_d = '0;
                pwrOk_d  = 1'b0;
                if (PWR_REQ) begin
                    state_d     = S_UP_WAIT;
                    idx_d       = '0;
                    cnt_d       = '0;
                    railEn_d[0] = 1'b1;
                end
            end

            S_UP_WAIT: begin
                cnt_d = (cnt_q == PG_LAST) ? cnt_q : cnt_q + CNT_ONE;
                if (|(belowIdx & ~pgS_q)) begin
                    state_d    = S_FAULT;
                    faultIdx_d = lowestSet(belowIdx & ~pgS_q);
                end else if (!PWR_REQ) begin
                    state_d         = S_DOWN;
                    cnt_d           = '0;
                    railEn_d[idx_q] = 1'b0;
                end else if (pgS_q[idx_q]) begin
                    state_d = S_UP_DLY;
                    cnt_d   = '0;
                end else if (cnt_q == PG_LAST) begin
                    state_d    = S_FAULT;
                    faultIdx_d = idx_q;
                end
            end

            S_UP_DLY: begin
                cnt_d = (cnt_q == STEP_LAST) ? cnt_q : cnt_q + CNT_ONE;
                if (|(atOrBelowIdx & ~pgS_q)) begin
                    state_d    = S_FAULT;
                    faultIdx_d = lowestSet(atOrBelowIdx & ~pgS_q);
                end else if (!PWR_REQ) begin
                    state_d         = S_DOWN;
                    cnt_d           = '0;
                    railEn_d[idx_q] = 1'b0;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_ON;
                        pwrOk_d = 1'b1;
                    end else begin
                        state_d         = S_UP_WAIT;
                        idx_d           = idx_q + IDX_ONE;
                        railEn_d[idx_d] = 1'b1;
                    end
                end
            end

            S_ON: begin
                pwrOk_d = 1'b1;
                if (|onLost) begin
                    state_d    = S_FAULT;
                    faultIdx_d = lowestSet(onLost);
                end else if (!PWR_REQ) begin
                    state_d            = S_DOWN;
                    pwrOk_d            = 1'b0;
                    idx_d              = LAST_IDX;
                    cnt_d              = '0;
                    railEn_d[LAST_IDX] = 1'b0;
                end
            end

            S_DOWN: begin
                cnt_d = (cnt_q == STEP_LAST) ? cnt_q : cnt_q + CNT_ONE;
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        idx_d           = idx_q - IDX_ONE;
                        railEn_d[idx_d] = 1'b0;
                    end
                end
            end

            S_FAULT: begin
                railEn_d = '0;
                pwrOk_d  = 1'b0;
                fault_d  = 1'b1;
                if (CLR_FAULT && !PWR_REQ) begin
                    state_d = S_OFF;
                    fault_d = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_OFF;
            end
        endcase

        // Entering FAULT drops every rail together rather than sequencing them down.
        if (state_d == S_FAULT && state_q != S_FAULT) begin
            railEn_d = '0;
            pwrOk_d  = 1'b0;
            fault_d  = 1'b1;
            cnt_d    = '0;
        end
    end

    assign RAIL_EN   = railEn_q;
    assign PWR_OK    = pwrOk_q;
    assign FAULT     = fault_q;
    assign FAULT_IDX = faultIdx_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed testbench for pwr_seq_ctrl with a PG model that follows each rail enable after one cycle.
// Define PWR_SEQ_PG_FILTER_EN for both files to exercise the filtered ON-state behaviour.
module tb_pwr_seq_ctrl;

    logic       SYSCLK = 1'b0;
    logic       RESET;
    logic       PWR_REQ;
    logic       CLR_FAULT;
    logic [3:0] PG_IN;
    logic [3:0] RAIL_EN;
    logic       PWR_OK;
    logic       FAULT;
    logic [1:0] FAULT_IDX;

    logic [3:0] pgFollow = 4'b0000;
    logic [3:0] pgKill   = 4'b0000;

    int checks = 0;
    int errors = 0;

`ifdef PWR_SEQ_PG_FILTER_EN
    localparam int FILT_EXTRA = 2;
`else
    localparam int FILT_EXTRA = 0;
`endif

    pwr_seq_ctrl #(
        .NUM_RAILS (4),
        .IDX_W     (2),
        .CNT_W     (16),
        .STEP_DLY  (16'd4),
        .PG_TIMEOUT(16'd16),
        .PG_FILT   (3)
    ) dut (
        .SYSCLK   (SYSCLK),
        .RESET    (RESET),
        .PWR_REQ  (PWR_REQ),
        .PG_IN    (PG_IN),
        .CLR_FAULT(CLR_FAULT),
        .RAIL_EN  (RAIL_EN),
        .PWR_OK   (PWR_OK),
        .FAULT    (FAULT),
        .FAULT_IDX(FAULT_IDX)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Each regulator reports good one cycle after its enable, unless the bench forces it low.
    always @(posedge SYSCLK) pgFollow <= RAIL_EN;
    assign PG_IN = pgFollow & ~pgKill;

    task automatic waitRail(input logic [3:0] want, input int budget, output int n);
        n = 0;
        do begin
            @(negedge SYSCLK);
            n++;
        end while (RAIL_EN !== want && n < budget);
        if (RAIL_EN !== want) n = -1;
    endtask

    task automatic waitPwrOk(input int budget, output int n);
        n = 0;
        do begin
            @(negedge SYSCLK);
            n++;
        end while (PWR_OK !== 1'b1 && n < budget);
        if (PWR_OK !== 1'b1) n = -1;
    endtask

    task automatic waitFault(input int budget, output int n);
        n = 0;
        do begin
            @(negedge SYSCLK);
            n++;
        end while (FAULT !== 1'b1 && n < budget);
        if (FAULT !== 1'b1) n = -1;
    endtask

    task automatic bringUp(output int n);
        PWR_REQ = 1'b1;
        waitPwrOk(80, n);
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge SYSCLK);
    endtask

    task automatic test_reset;
        RESET     = 1'b1;
        PWR_REQ   = 1'b0;
        CLR_FAULT = 1'b0;
        pgKill    = 4'b0000;
        settle(3);
        RESET = 1'b0;
        settle(1);
        checks++;
        if (RAIL_EN !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_rail_en: got %b want %b", RAIL_EN, 4'b0000);
        end
        checks++;
        if (PWR_OK !== 1'b0 || FAULT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ok=%b fault=%b want ok=0 fault=0", PWR_OK, FAULT);
        end
        checks++;
        if (FAULT_IDX !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_fault_idx: got %0d want 0", FAULT_IDX);
        end
    endtask

    task automatic test_normal_updown;
        logic [3:0] upSeq [4];
        logic [3:0] dnSeq [4];
        int         upGap [4];
        int         n;
        upSeq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        upGap = '{1, 8, 8, 8};
        dnSeq = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
        PWR_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waitRail(upSeq[k], 20, n);
            checks++;
            if (n !== upGap[k]) begin
                errors++;
                $display("[TB] FAIL up_step_%0d: got %0d cycles want %0d (rail_en=%b)", k, n, upGap[k], RAIL_EN);
            end
        end
        waitPwrOk(20, n);
        checks++;
        if (n !== 8 || RAIL_EN !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL pwr_ok_rise: got %0d cycles rail_en=%b want 8 cycles 1111", n, RAIL_EN);
        end
        settle(3);
        PWR_REQ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitRail(dnSeq[k], 10, n);
            checks++;
            if (n !== ((k == 0) ? 1 : 4)) begin
                errors++;
                $display("[TB] FAIL down_step_%0d: got %0d cycles want %0d", k, n, (k == 0) ? 1 : 4);
            end
            if (k == 0) begin
                checks++;
                if (PWR_OK !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL down_pwr_ok: got %b want 0", PWR_OK);
                end
            end
        end
        settle(6);
    endtask

    task automatic test_timeout;
        int n;
        pgKill  = 4'b0100;
        PWR_REQ = 1'b1;
        waitRail(4'b0111, 40, n);
        checks++;
        if (n !== 17) begin
            errors++;
            $display("[TB] FAIL timeout_rail2_on: got %0d cycles want 17", n);
        end
        waitFault(30, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got %0d cycles want 16", n);
        end
        checks++;
        if (FAULT_IDX !== 2'd2 || RAIL_EN !== 4'b0000 || PWR_OK !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_state: got idx=%0d rail_en=%b ok=%b want idx=2 rail_en=0000 ok=0",
                     FAULT_IDX, RAIL_EN, PWR_OK);
        end
        CLR_FAULT = 1'b1;
        settle(3);
        checks++;
        if (FAULT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_with_req: got fault=%b want 1", FAULT);
        end
        CLR_FAULT = 1'b0;
        PWR_REQ   = 1'b0;
        settle(2);
        checks++;
        if (FAULT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fault_hold_no_clear: got fault=%b want 1", FAULT);
        end
        CLR_FAULT = 1'b1;
        settle(1);
        checks++;
        if (FAULT !== 1'b0 || FAULT_IDX !== 2'd2) begin
            errors++;
            $display("[TB] FAIL fault_clear: got fault=%b idx=%0d want fault=0 idx=2", FAULT, FAULT_IDX);
        end
        CLR_FAULT = 1'b0;
        pgKill    = 4'b0000;
        settle(3);
    endtask

    task automatic test_pg_on_timeout;
        pgKill  = 4'b0001;
        PWR_REQ = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge SYSCLK);
            if (k == 13) pgKill = 4'b0000;
            if (k == 16) begin
                checks++;
                if (FAULT !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL pg_at_timeout_no_fault: got fault=%b want 0", FAULT);
                end
            end
        end
        checks++;
        if (RAIL_EN !== 4'b0011 || FAULT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pg_at_timeout_advance: got rail_en=%b fault=%b want 0011 0", RAIL_EN, FAULT);
        end
        PWR_REQ = 1'b0;
        settle(20);
    endtask

    task automatic test_abort;
        int n;
        PWR_REQ = 1'b1;
        waitRail(4'b0011, 20, n);
        checks++;
        if (n !== 9) begin
            errors++;
            $display("[TB] FAIL abort_reach_0011: got %0d cycles want 9", n);
        end
        PWR_REQ = 1'b0;
        settle(1);
        checks++;
        if (RAIL_EN !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL abort_first_step: got %b want 0001", RAIL_EN);
        end
        waitRail(4'b0000, 10, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("[TB] FAIL abort_second_step: got %0d cycles want 4", n);
        end
        settle(6);
    endtask

    task automatic test_on_glitch;
        int n;
        bringUp(n);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("[TB] FAIL glitch_bring_up: got %0d cycles want 33", n);
        end
        settle(2);
`ifdef PWR_SEQ_PG_FILTER_EN
        pgKill = 4'b0010;
        settle(2);
        pgKill = 4'b0000;
        settle(4);
        checks++;
        if (FAULT !== 1'b0 || PWR_OK !== 1'b1) begin
            errors++;
            $display("[TB] FAIL filter_two_low: got fault=%b ok=%b want 0 1", FAULT, PWR_OK);
        end
        pgKill = 4'b0010;
        settle(3);
        pgKill = 4'b0000;
        settle(1);
        checks++;
        if (FAULT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL filter_early: got fault=%b want 0", FAULT);
        end
        settle(1);
`else
        pgKill = 4'b0010;
        settle(1);
        pgKill = 4'b0000;
        settle(1);
        checks++;
        if (FAULT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_early: got fault=%b want 0", FAULT);
        end
        settle(1);
`endif
        checks++;
        if (FAULT !== 1'b1 || FAULT_IDX !== 2'd1 || RAIL_EN !== 4'b0000 || PWR_OK !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_fault: got fault=%b idx=%0d rail_en=%b ok=%b want 1 1 0000 0",
                     FAULT, FAULT_IDX, RAIL_EN, PWR_OK);
        end
        PWR_REQ   = 1'b0;
        CLR_FAULT = 1'b1;
        settle(1);
        CLR_FAULT = 1'b0;
        settle(3);
    endtask

    task automatic test_simultaneous;
        int n;
        bringUp(n);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("[TB] FAIL simul_bring_up: got %0d cycles want 33", n);
        end
        settle(2);
        pgKill = 4'b1100;
        for (int k = 1; k <= 3 + FILT_EXTRA; k++) begin
            @(negedge SYSCLK);
            if (k == 2 + FILT_EXTRA) PWR_REQ = 1'b0;
        end
        checks++;
        if (FAULT !== 1'b1 || FAULT_IDX !== 2'd2 || RAIL_EN !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL simul_fault_wins: got fault=%b idx=%0d rail_en=%b want 1 2 0000",
                     FAULT, FAULT_IDX, RAIL_EN);
        end
        pgKill    = 4'b0000;
        CLR_FAULT = 1'b1;
        settle(1);
        CLR_FAULT = 1'b0;
        settle(3);
    endtask

    task automatic test_reset_in_on;
        int n;
        bringUp(n);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("[TB] FAIL reset_on_bring_up: got %0d cycles want 33", n);
        end
        settle(2);
        RESET = 1'b1;
        settle(1);
        checks++;
        if (RAIL_EN !== 4'b0000 || PWR_OK !== 1'b0 || FAULT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_on: got rail_en=%b ok=%b fault=%b want 0000 0 0",
                     RAIL_EN, PWR_OK, FAULT);
        end
        PWR_REQ = 1'b0;
        settle(1);
        RESET = 1'b0;
        settle(2);
    endtask

    initial begin
        test_reset;
        test_normal_updown;
        test_timeout;
        test_pg_on_timeout;
        test_abort;
        test_on_glitch;
        test_simultaneous;
        test_reset_in_on;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
